// File: rtl/sam_pkg.sv
// Shared SAM CPU definitions: memory-interface FSM states, default bus widths
// and the bit positions of the memory controls in the bus_controller word.
package sam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2
  } mem_state_t;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  // Bit indices of the memory-interface controls inside bus_controller.
  localparam int BC_MAR_LD = 0;
  localparam int BC_MDR_LD = 1;
  localparam int BC_MEM_RD = 2;
  localparam int BC_MEM_WR = 3;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM. Registered read; a read during a write to the
// same address returns the old word. Contents are never reset.
module mem_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write on we; the read register always captures the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_interface.sv
// SAM memory interface: MAR/MDR, multi-cycle read/write sequencing and the
// wait_ stall flag back to the microprogrammed controller.
//
//   state   | meaning
//   IDLE    | registers loadable, accepts one read or write request
//   BUSY_RD | read in flight, MAR/MDR frozen, MDR <= M[MAR] when cnt hits 0
//   BUSY_WR | write in flight, MAR/MDR frozen, M[MAR] <= MDR when cnt hits 0
module mem_interface
  import sam_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mar_ld,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic              mdr_ld,
  input  logic [DATA_W-1:0] mdr_in,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic              wait_,
  output logic              err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_state_t        state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] mar_d;
  logic [DATA_W-1:0] mdr_q;
  logic              wait_q;
  logic              err_q;
  logic              done;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // The access completes on the edge after the counter reaches zero.
  assign done   = (state_q != IDLE) && (cnt_q == 4'd0);
  assign ram_we = (state_q == BUSY_WR) && done;

  // The RAM is addressed with next-MAR so a same-edge mar_ld + mem_rd starts
  // reading the new address at the request edge; this keeps LATENCY=1 exact.
  assign mar_d = ((state_q == IDLE) && mar_ld) ? mar_in : mar_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (mar_d),
    .wdata (mdr_q),
    .rdata (ram_rdata)
  );

  // Access sequencer with registered wait_/err outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= '0;
      mdr_q   <= '0;
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mar_q <= mar_d;
          if (mdr_ld) mdr_q <= mdr_in;
          if (mem_rd && mem_wr) begin
            err_q <= 1'b1;
          end else if (mem_rd) begin
            state_q <= BUSY_RD;
            cnt_q   <= CNT_INIT;
            wait_q  <= 1'b1;
          end else if (mem_wr) begin
            state_q <= BUSY_WR;
            cnt_q   <= CNT_INIT;
            wait_q  <= 1'b1;
          end
        end
        BUSY_RD, BUSY_WR: begin
          if (mar_ld || mdr_ld || mem_rd || mem_wr) err_q <= 1'b1;
          if (!done) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
            if (state_q == BUSY_RD) mdr_q <= ram_rdata;
          end
        end
        default: begin
          state_q <= IDLE;
          wait_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mar_out = mar_q;
  assign mdr_out = mdr_q;
  assign wait_   = wait_q;
  assign err     = err_q;

endmodule
